// File: rtl/irig_uart_pkg.sv
// Shared constants, FSM encoding and snapshot layout for the IRIG-B time to UART record packer.
package irig_uart_pkg;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  localparam int         REC_LEN  = 14;
  localparam logic [3:0] IDX_LAST = 4'(REC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [9:0] day;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } snap_t;

endpackage

// File: rtl/bcd_nib_to_ascii.sv
// One BCD nibble to its ASCII digit; anything above 9 becomes '?'.
module bcd_nib_to_ascii
  import irig_uart_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    asc = (nib > 4'd9) ? ASC_QMARK : (ASC_ZERO | {4'b0000, nib});
  end

endmodule

// File: rtl/irig_time_uart_packer.sv
// Snapshots IRIG-B BCD time and streams "DDD HH:MM:SS\r\n" one byte per UART frame slot.
// po_flag spacing is self-timed because the downstream transmitter gives no ready signal.
module irig_time_uart_packer
  import irig_uart_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_BITS = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       time_valid,
  input  logic [6:0] sec_bcd,
  input  logic [6:0] min_bcd,
  input  logic [5:0] hour_bcd,
  input  logic [9:0] day_bcd,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       busy,
  output logic       overrun
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int          GAP_MAX      = BAUD_CNT_MAX * GAP_BITS;
  localparam logic [19:0] GAP_LAST     = 20'(GAP_MAX - 1);

  state_e      state_q, state_d;
  snap_t       snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic [19:0] gap_q, gap_d;
  logic [7:0]  data_q, data_d;
  logic        flag_q, flag_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [3:0]  nib;
  logic [7:0]  nib_asc;
  logic [7:0]  fixed_chr;
  logic        is_digit;
  logic [7:0]  chr;

  // Single converter shared by every digit position; idx picks the nibble.
  always_comb begin
    nib       = 4'd0;
    is_digit  = 1'b1;
    fixed_chr = ASC_SP;
    case (idx_q)
      4'd0:    nib = {2'b00, snap_q.day[9:8]};
      4'd1:    nib = snap_q.day[7:4];
      4'd2:    nib = snap_q.day[3:0];
      4'd3:    begin is_digit = 1'b0; fixed_chr = ASC_SP;    end
      4'd4:    nib = {2'b00, snap_q.hour[5:4]};
      4'd5:    nib = snap_q.hour[3:0];
      4'd6:    begin is_digit = 1'b0; fixed_chr = ASC_COLON; end
      4'd7:    nib = {1'b0, snap_q.min[6:4]};
      4'd8:    nib = snap_q.min[3:0];
      4'd9:    begin is_digit = 1'b0; fixed_chr = ASC_COLON; end
      4'd10:   nib = {1'b0, snap_q.sec[6:4]};
      4'd11:   nib = snap_q.sec[3:0];
      4'd12:   begin is_digit = 1'b0; fixed_chr = ASC_CR;    end
      default: begin is_digit = 1'b0; fixed_chr = ASC_LF;    end
    endcase
  end

  bcd_nib_to_ascii u_nib2asc (
    .nib (nib),
    .asc (nib_asc)
  );

  assign chr = is_digit ? nib_asc : fixed_chr;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    data_d    = data_q;
    flag_d    = 1'b0;
    busy_d    = busy_q;
    // Any pulse outside IDLE is dropped, including one on the edge that returns to IDLE.
    overrun_d = time_valid && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (time_valid) begin
          snap_d  = '{day: day_bcd, hour: hour_bcd, min: min_bcd, sec: sec_bcd};
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        data_d  = chr;
        flag_d  = 1'b1;
        gap_d   = 20'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end else begin
          gap_d = gap_q + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= 4'd0;
      gap_q     <= 20'd0;
      data_q    <= ASC_SP;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign po_data = data_q;
  assign po_flag = flag_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irig_time_uart_packer.sv
// Directed + randomized bench for irig_time_uart_packer with a string-level record model.
module tb_irig_time_uart_packer;

  localparam int PITCH = 111;  // GAP_MAX + 1 with 1 MHz clock, 100 kBd, 11 bit slots

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       time_valid = 1'b0;
  logic [6:0] sec_bcd = '0;
  logic [6:0] min_bcd = '0;
  logic [5:0] hour_bcd = '0;
  logic [9:0] day_bcd = '0;
  logic [7:0] po_data;
  logic       po_flag;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ov_cnt = 0;
  logic [7:0] fdat[$];
  int         fcyc[$];
  logic [7:0] last_dat = 8'h20;

  irig_time_uart_packer #(
    .UART_BPS (100_000),
    .CLK_FREQ (1_000_000),
    .GAP_BITS (11)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .time_valid (time_valid),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .hour_bcd   (hour_bcd),
    .day_bcd    (day_bcd),
    .po_data    (po_data),
    .po_flag    (po_flag),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Log every strobe; between strobes the byte must not move.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      last_dat = 8'h20;
    end else begin
      if (po_flag) begin
        fdat.push_back(po_data);
        fcyc.push_back(cyc);
      end else begin
        chk("hold", {24'd0, po_data}, {24'd0, last_dat});
      end
      last_dat = po_data;
      if (overrun) ov_cnt++;
    end
  end

  function automatic logic [7:0] asc_dig(input int v);
    if (v > 9) return 8'h3F;
    return 8'(48 + v);
  endfunction

  // Byte i of the record sits at [8*i +: 8].
  function automatic logic [111:0] model_rec(input logic [9:0] d, input logic [5:0] h,
                                             input logic [6:0] m, input logic [6:0] s);
    logic [7:0]   c[14];
    logic [111:0] r;
    int di, hi, mi, si;
    di = int'(d); hi = int'(h); mi = int'(m); si = int'(s);
    c[0]  = asc_dig(di / 256);
    c[1]  = asc_dig((di / 16) % 16);
    c[2]  = asc_dig(di % 16);
    c[3]  = 8'h20;
    c[4]  = asc_dig(hi / 16);
    c[5]  = asc_dig(hi % 16);
    c[6]  = 8'h3A;
    c[7]  = asc_dig(mi / 16);
    c[8]  = asc_dig(mi % 16);
    c[9]  = 8'h3A;
    c[10] = asc_dig(si / 16);
    c[11] = asc_dig(si % 16);
    c[12] = 8'h0D;
    c[13] = 8'h0A;
    r = '0;
    for (int i = 0; i < 14; i++) r[8*i +: 8] = c[i];
    return r;
  endfunction

  // Call right after a negedge; afterwards the inputs are scrambled to prove the snapshot is frozen.
  task automatic pulse_tv(input logic [9:0] d, input logic [5:0] h, input logic [6:0] m,
                          input logic [6:0] s, output int t);
    day_bcd = d; hour_bcd = h; min_bcd = m; sec_bcd = s;
    time_valid = 1'b1;
    t = cyc;
    @(negedge sys_clk);
    time_valid = 1'b0;
    day_bcd  = 10'($urandom);
    hour_bcd = 6'($urandom);
    min_bcd  = 7'($urandom);
    sec_bcd  = 7'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic check_rec(input string tag, input int base, input logic [111:0] exp, input int t0);
    logic [7:0] got_b;
    int         got_c;
    for (int i = 0; i < 14; i++) begin
      if (base + i < fdat.size()) begin
        got_b = fdat[base + i];
        got_c = fcyc[base + i];
      end else begin
        got_b = 8'hxx;
        got_c = -1;
      end
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_b}, {24'd0, exp[8*i +: 8]});
      chk($sformatf("%s_time%0d", tag, i), got_c, t0 + 2 + PITCH * i);
    end
  endtask

  function automatic logic [7:0] qbyte(input int i);
    if (i < fdat.size()) return fdat[i];
    return 8'hxx;
  endfunction

  initial begin
    int t0, t1;
    logic [9:0] d, d2;
    logic [5:0] h, h2;
    logic [6:0] m, m2, s, s2;

    // Reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_po_data", {24'd0, po_data}, 32'h20);
    chk("rst_po_flag", {31'd0, po_flag}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    #2 sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Nominal record, latency and pacing
    ov_cnt = 0; fdat.delete(); fcyc.delete();
    pulse_tv(10'h123, 6'h23, 7'h59, 7'h58, t0);
    wait_until(t0 + 1700);
    check_rec("nominal", 0, model_rec(10'h123, 6'h23, 7'h59, 7'h58), t0);
    chk("nominal_first", {24'd0, qbyte(0)}, 32'h31);
    chk("nominal_last", {24'd0, qbyte(13)}, 32'h0A);
    chk("nominal_count", fdat.size(), 14);
    chk("nominal_busy_end", {31'd0, busy}, 0);
    chk("nominal_data_kept", {24'd0, po_data}, 32'h0A);
    chk("nominal_no_overrun", ov_cnt, 0);

    // Invalid BCD nibbles become '?'
    fdat.delete(); fcyc.delete();
    d = 10'($urandom);
    m = 7'($urandom);
    pulse_tv(d, 6'h3F, m, 7'h5C, t0);
    wait_until(t0 + 1700);
    check_rec("badbcd", 0, model_rec(d, 6'h3F, m, 7'h5C), t0);
    chk("badbcd_b4", {24'd0, qbyte(4)}, 32'h33);
    chk("badbcd_b5", {24'd0, qbyte(5)}, 32'h3F);
    chk("badbcd_b10", {24'd0, qbyte(10)}, 32'h35);
    chk("badbcd_b11", {24'd0, qbyte(11)}, 32'h3F);

    // Random fields, including out-of-range nibbles
    for (int r = 0; r < 2; r++) begin
      fdat.delete(); fcyc.delete();
      d = 10'($urandom); h = 6'($urandom); m = 7'($urandom); s = 7'($urandom);
      pulse_tv(d, h, m, s, t0);
      wait_until(t0 + 1700);
      check_rec($sformatf("rand%0d", r), 0, model_rec(d, h, m, s), t0);
      chk($sformatf("rand%0d_count", r), fdat.size(), 14);
    end

    // time_valid mid-record
    ov_cnt = 0; fdat.delete(); fcyc.delete();
    d = 10'h301; h = 6'h12; m = 7'h34; s = 7'h07;
    pulse_tv(d, h, m, s, t0);
    wait_until(t0 + 500);
    pulse_tv(10'h222, 6'h11, 7'h22, 7'h33, t1);
    wait_until(t0 + 2000);
    check_rec("midrec", 0, model_rec(d, h, m, s), t0);
    chk("midrec_count", fdat.size(), 14);
    chk("midrec_overrun", ov_cnt, 1);
    chk("midrec_busy", {31'd0, busy}, 0);

    // time_valid on the very edge that returns to IDLE
    ov_cnt = 0; fdat.delete(); fcyc.delete();
    d = 10'h065; h = 6'h09; m = 7'h41; s = 7'h26;
    pulse_tv(d, h, m, s, t0);
    wait_until(t0 + 2 + 13 * PITCH + 109);
    pulse_tv(10'h111, 6'h01, 7'h02, 7'h03, t1);
    wait_until(t0 + 2 + 13 * PITCH + 112);
    chk("edge_busy", {31'd0, busy}, 0);
    wait_until(t0 + 2100);
    check_rec("edge", 0, model_rec(d, h, m, s), t0);
    chk("edge_count", fdat.size(), 14);
    chk("edge_overrun", ov_cnt, 1);

    // Reset while byte 6 is on the line
    fdat.delete(); fcyc.delete();
    pulse_tv(10'h199, 6'h22, 7'h33, 7'h44, t0);
    while (fdat.size() < 7 && cyc < t0 + 1000) @(negedge sys_clk);
    chk("rst_mid_reached", fdat.size(), 7);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_po_data", {24'd0, po_data}, 32'h20);
    chk("rst_mid_po_flag", {31'd0, po_flag}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge sys_clk);
    chk("rst_mid_hold_busy", {31'd0, busy}, 0);
    #2 sys_rst_n = 1'b1;
    fdat.delete(); fcyc.delete();
    @(negedge sys_clk);
    wait_until(cyc + 300);
    chk("rst_mid_no_resume", fdat.size(), 0);
    chk("rst_mid_idle_busy", {31'd0, busy}, 0);
    d = 10'($urandom); h = 6'($urandom); m = 7'($urandom); s = 7'($urandom);
    pulse_tv(d, h, m, s, t0);
    wait_until(t0 + 1700);
    check_rec("after_rst", 0, model_rec(d, h, m, s), t0);

    // Back-to-back seconds, 2000 cycles apart
    ov_cnt = 0; fdat.delete(); fcyc.delete();
    d = 10'h200; h = 6'h23; m = 7'h59; s = 7'h59;
    d2 = 10'h201; h2 = 6'h00; m2 = 7'h00; s2 = 7'h00;
    pulse_tv(d, h, m, s, t0);
    wait_until(t0 + 2000);
    pulse_tv(d2, h2, m2, s2, t1);
    wait_until(t1 + 1700);
    check_rec("b2b_a", 0, model_rec(d, h, m, s), t0);
    check_rec("b2b_b", 14, model_rec(d2, h2, m2, s2), t1);
    chk("b2b_count", fdat.size(), 28);
    chk("b2b_no_overrun", ov_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
